// File: rtl/cavlc_level_dec.sv
// CAVLC level decoder: parses level_prefix / level_suffix from a serial
// bitstream, rebuilds each signed level with suffixLength adaptation and
// hands the levels downstream in bitstream order.
//
// Handshakes: a bit moves when bit_valid && bit_ready; a level moves when
// lvl_valid && lvl_ready. A producer holds its data stable while its valid
// is high and ready is low. bit_ready and lvl_valid depend only on state,
// never combinationally on the partner's valid/ready.
module cavlc_level_dec #(
  parameter int RES_WIDTH  = 16,
  parameter int MAX_PREFIX = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,       // active-high despite the name
  input  logic                 start,
  input  logic [4:0]           total_coeff,
  input  logic [1:0]           trail_ones,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [RES_WIDTH-1:0] lvl,
  output logic                 lvl_valid,
  input  logic                 lvl_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           dbg_state,
  output logic [2:0]           dbg_sl
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREFIX = 3'd1,
    S_SUFFIX = 3'd2,
    S_CALC   = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [4:0]  num;        // levels still to decode
  logic [4:0]  prefix;
  logic [1:0]  to_q;       // latched trail_ones
  logic        first;      // next level is the first non-trailing-one level
  logic [2:0]  sl;         // suffixLength
  logic [3:0]  cnt;        // suffix bits still to shift in
  logic [14:0] suffix;
  logic        done_q;
  logic        err_q;

  logic        start_ok;
  logic [4:0]  num_in;
  logic        prefix_over;
  logic [3:0]  size_calc;
  logic [4:0]  pmin;
  logic [17:0] lc;
  logic [17:0] mag;
  logic [17:0] lvl_wide;
  logic [2:0]  sl1;
  logic [2:0]  sl_next;

  // A start in the done cycle is ignored, so acceptance is gated by done_q.
  assign start_ok    = (state == S_IDLE) && start && !done_q;
  assign num_in      = total_coeff - {3'b000, trail_ones};
  assign prefix_over = (prefix == 5'(MAX_PREFIX));
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state   = state;
  assign dbg_sl      = sl;

  // Suffix size from the completed prefix and current suffixLength.
  always_comb begin
    size_calc = {1'b0, sl};
    if (prefix >= 5'd15)
      size_calc = 4'(prefix - 5'd3);
    else if (prefix == 5'd14 && sl == 3'd0)
      size_calc = 4'd4;
  end

  // levelCode reconstruction, signed level and next suffixLength.
  always_comb begin
    pmin = (prefix > 5'd15) ? 5'd15 : prefix;
    lc   = 18'(pmin) << sl;
    lc   = lc + 18'(suffix);
    if (prefix >= 5'd15 && sl == 3'd0)
      lc = lc + 18'd15;
    if (prefix >= 5'd16)
      lc = lc + (18'd1 << (prefix - 5'd3)) - 18'd4096;
    if (first && to_q != 2'd3)
      lc = lc + 18'd2;
    mag      = lc[0] ? ((lc + 18'd1) >> 1) : ((lc + 18'd2) >> 1);
    lvl_wide = lc[0] ? (18'd0 - mag) : mag;
    sl1      = (sl == 3'd0) ? 3'd1 : sl;
    sl_next  = sl1;
    if (mag > (18'd3 << (sl1 - 3'd1)) && sl1 < 3'd6)
      sl_next = sl1 + 3'd1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    bit_ready = 1'b0;
    lvl_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start_ok && num_in != 5'd0) state_nxt = S_PREFIX;
      end
      S_PREFIX: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          if (!bit_in) begin
            if (prefix_over) state_nxt = S_IDLE;
          end else begin
            state_nxt = (size_calc == 4'd0) ? S_CALC : S_SUFFIX;
          end
        end
      end
      S_SUFFIX: begin
        bit_ready = 1'b1;
        if (bit_valid && cnt == 4'd1) state_nxt = S_CALC;
      end
      S_CALC: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        lvl_valid = 1'b1;
        if (lvl_ready) state_nxt = (num == 5'd0) ? S_IDLE : S_PREFIX;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers and the done/err pulses.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      num    <= '0;
      prefix <= '0;
      to_q   <= '0;
      first  <= 1'b0;
      sl     <= '0;
      cnt    <= '0;
      suffix <= '0;
      lvl    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            num    <= num_in;
            to_q   <= trail_ones;
            first  <= 1'b1;
            prefix <= '0;
            suffix <= '0;
            sl     <= (total_coeff > 5'd10 && trail_ones != 2'd3) ? 3'd1 : 3'd0;
            if (num_in == 5'd0) done_q <= 1'b1;
          end
        end
        S_PREFIX: begin
          if (bit_valid) begin
            if (!bit_in) begin
              if (prefix_over) err_q <= 1'b1;
              else             prefix <= prefix + 5'd1;
            end else begin
              cnt    <= size_calc;
              suffix <= '0;
            end
          end
        end
        S_SUFFIX: begin
          if (bit_valid) begin
            suffix <= {suffix[13:0], bit_in};
            cnt    <= cnt - 4'd1;
          end
        end
        S_CALC: begin
          lvl   <= RES_WIDTH'(lvl_wide);
          sl    <= sl_next;
          first <= 1'b0;
          num   <= num - 5'd1;
        end
        S_OUT: begin
          if (lvl_ready) begin
            if (num == 5'd0) begin
              done_q <= 1'b1;
            end else begin
              prefix <= '0;
              suffix <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_level_dec.sv
// Bench for cavlc_level_dec. The reference side is an encoder: it turns
// chosen signed levels into level_prefix/level_suffix bits using the
// suffixLength rules, so the expected decoder output is the levels chosen.
module tb_cavlc_level_dec;
  localparam int RES_WIDTH = 16;
  localparam int W = RES_WIDTH;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [4:0]    total_coeff;
  logic [1:0]    trail_ones;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [W-1:0]  lvl;
  logic          lvl_valid;
  logic          lvl_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    dbg_state;
  logic [2:0]    dbg_sl;

  int tests_run = 0;
  int tests_failed = 0;

  logic         bit_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  cavlc_level_dec #(.RES_WIDTH(RES_WIDTH), .MAX_PREFIX(18)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .total_coeff(total_coeff),
    .trail_ones(trail_ones), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .lvl(lvl), .lvl_valid(lvl_valid),
    .lvl_ready(lvl_ready), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state), .dbg_sl(dbg_sl)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push a literal bit string onto the stimulus queue.
  task automatic push_bits(input string s);
    for (int i = 0; i < s.len(); i++) bit_q.push_back(s[i] == "1");
  endtask

  // Encode one level into prefix/suffix bits and track suffixLength.
  task automatic encode_level(input int v, input bit first_lvl, input int to, inout int sl);
    int lc, prefix, size, suf, rem, p, a;
    lc = (v > 0) ? 2 * v - 2 : -2 * v - 1;
    if (first_lvl && to < 3) lc = lc - 2;
    if (sl == 0 && lc < 14) begin
      prefix = lc; size = 0; suf = 0;
    end else if (sl == 0 && lc < 30) begin
      prefix = 14; size = 4; suf = lc - 14;
    end else if (sl > 0 && lc < (15 << sl)) begin
      prefix = lc >> sl; size = sl; suf = lc & ((1 << sl) - 1);
    end else begin
      rem = lc - (15 << sl) - ((sl == 0) ? 15 : 0);
      if (rem < 4096) begin
        prefix = 15; size = 12; suf = rem;
      end else begin
        p = 16;
        while (rem - ((1 << (p - 3)) - 4096) >= (1 << (p - 3))) p++;
        prefix = p; size = p - 3; suf = rem - ((1 << (p - 3)) - 4096);
      end
    end
    for (int i = 0; i < prefix; i++) bit_q.push_back(1'b0);
    bit_q.push_back(1'b1);
    for (int i = size - 1; i >= 0; i--) bit_q.push_back(((suf >> i) & 1) == 1);
    exp_q.push_back(W'(v));
    a = (v < 0) ? -v : v;
    if (sl == 0) sl = 1;
    if (a > (3 << (sl - 1)) && sl < 6) sl = sl + 1;
  endtask

  // Build a random block of levels for the given TotalCoeff/TrailingOnes.
  task automatic build_block(input int tc, input int to, input int max_mag, output int sl_end);
    int sl, mag, v;
    bit_q.delete();
    exp_q.delete();
    sl = (tc > 10 && to < 3) ? 1 : 0;
    for (int k = 0; k < tc - to; k++) begin
      mag = ($urandom_range(0, 3) == 0) ? $urandom_range(1, max_mag) : $urandom_range(1, 8);
      if (k == 0 && to < 3 && mag < 2) mag = 2;
      v = ($urandom_range(0, 1) == 1) ? mag : -mag;
      encode_level(v, k == 0, to, sl);
    end
    sl_end = sl;
  endtask

  // Driver: start a block, feed bit_q with optional stalls and backpressure,
  // collect accepted levels into got_q until done or err or the budget runs out.
  task automatic drive_block(input logic [4:0] tc, input logic [1:0] to, input int stall_pct,
                             input int bp_pct, input int budget, output bit done_seen,
                             output bit err_seen, output int bits_used);
    got_q.delete();
    done_seen = 1'b0;
    err_seen = 1'b0;
    bits_used = 0;
    @(negedge clk);
    start = 1'b1; total_coeff = tc; trail_ones = to; bit_valid = 1'b0; lvl_ready = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin done_seen = 1'b1; break; end
      if (err) begin err_seen = 1'b1; break; end
      bit_valid = (bit_q.size() > 0) && ($urandom_range(0, 99) >= stall_pct);
      bit_in = (bit_q.size() > 0) ? bit_q[0] : 1'b0;
      lvl_ready = ($urandom_range(0, 99) >= bp_pct);
      if (bit_valid && bit_ready) begin void'(bit_q.pop_front()); bits_used++; end
      if (lvl_valid && lvl_ready) got_q.push_back(lvl);
    end
    bit_valid = 1'b0;
    lvl_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bit_ready, lvl, lvl_valid, busy, done, err, dbg_sl} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b lvl=%h vld=%b busy=%b done=%b err=%b sl=%0d, want all 0",
               bit_ready, lvl, lvl_valid, busy, done, err, dbg_sl);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    start = 1'b1; total_coeff = 5'd1; trail_ones = 2'd0; bit_valid = 1'b1; bit_in = 1'b1; lvl_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (bit_ready !== 1'b1 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL single_prefix: rdy=%b busy=%b, want 1 1", bit_ready, busy);
    end
    @(negedge clk);
    bit_valid = 1'b0;
    tests_run++;
    if (bit_ready !== 1'b0 || lvl_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_calc: rdy=%b vld=%b, want 0 0", bit_ready, lvl_valid);
    end
    @(negedge clk);
    tests_run++;
    if (lvl_valid !== 1'b1 || lvl !== 16'sd2) begin
      tests_failed++; $display("FAIL single_level: vld=%b lvl=%0d, want 1 2", lvl_valid, $signed(lvl));
    end
    lvl_ready = 1'b1;
    @(negedge clk);
    lvl_ready = 1'b0;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || lvl_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_done: done=%b busy=%b vld=%b, want 1 0 0", done, busy, lvl_valid);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("FAIL single_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_escapes();
    bit ds, es;
    int used;
    bit_q.delete();
    push_bits("00000000000000"); push_bits("1"); push_bits("0101");
    drive_block(5'd4, 2'd3, 0, 0, 200, ds, es, used);
    tests_run++;
    if (!ds || got_q.size() != 1 || got_q[0] !== 16'hFFF6 || used != 19) begin
      tests_failed++;
      $display("FAIL escape14: done=%b n=%0d lvl=%0d bits=%0d, want 1 1 -10 19",
               ds, got_q.size(), (got_q.size() > 0) ? $signed(got_q[0]) : 0, used);
    end
    bit_q.delete();
    push_bits("000000000000000"); push_bits("1"); push_bits("000000000000");
    drive_block(5'd4, 2'd3, 0, 0, 200, ds, es, used);
    tests_run++;
    if (!ds || got_q.size() != 1 || got_q[0] !== 16'd16 || used != 28) begin
      tests_failed++;
      $display("FAIL escape15: done=%b n=%0d lvl=%0d bits=%0d, want 1 1 16 28",
               ds, got_q.size(), (got_q.size() > 0) ? $signed(got_q[0]) : 0, used);
    end
  endtask

  task automatic test_boundary_prefix18();
    bit ds, es;
    int used, sl;
    bit_q.delete(); exp_q.delete();
    sl = 0;
    encode_level(-20000, 1'b1, 3, sl);
    drive_block(5'd4, 2'd3, 20, 20, 500, ds, es, used);
    tests_run++;
    if (!ds || es || got_q.size() != 1 || got_q[0] !== exp_q[0] || used != 34) begin
      tests_failed++;
      $display("FAIL prefix18: done=%b err=%b n=%0d lvl=%0d bits=%0d, want 1 0 1 -20000 34",
               ds, es, got_q.size(), (got_q.size() > 0) ? $signed(got_q[0]) : 0, used);
    end
  endtask

  task automatic test_sl_adapt();
    bit ds, es;
    int used, sl, v;
    bit_q.delete(); exp_q.delete();
    push_bits("10"); exp_q.push_back(W'(2));
    push_bits("00011"); exp_q.push_back(W'(-4));
    sl = 2;
    for (int k = 0; k < 9; k++) begin
      v = $urandom_range(200, 1000);
      if ($urandom_range(0, 1) == 1) v = -v;
      encode_level(v, 1'b0, 0, sl);
    end
    drive_block(5'd11, 2'd0, 10, 30, 3000, ds, es, used);
    tests_run++;
    if (!ds || got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL adapt_count: done=%b n=%0d, want 1 %0d", ds, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL adapt_level[%0d]: got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i]));
        end
      end
    end
    tests_run++;
    if (dbg_sl !== 3'd6) begin
      tests_failed++; $display("FAIL adapt_sl_cap: sl=%0d want 6", dbg_sl);
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] seq;
    int fed;
    seq = 7'b0000001;
    fed = 0;
    @(negedge clk);
    start = 1'b1; total_coeff = 5'd1; trail_ones = 2'd0; bit_valid = 1'b0; lvl_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && !lvl_valid; c++) begin
      if (c == 3) begin
        tests_run++;
        if (bit_ready !== 1'b1) begin
          tests_failed++; $display("FAIL stall_ready: rdy=%b want 1", bit_ready);
        end
      end
      bit_valid = (c != 3) && (fed < 7);
      bit_in = (fed < 7) ? seq[6 - fed] : 1'b0;
      if (bit_valid && bit_ready) fed++;
      @(negedge clk);
    end
    tests_run++;
    if (fed != 7 || lvl_valid !== 1'b1) begin
      tests_failed++; $display("FAIL stall_bits: bits=%0d vld=%b want 7 1", fed, lvl_valid);
    end
    for (int c = 0; c < 3; c++) begin
      bit_valid = 1'b1; bit_in = 1'b0; lvl_ready = 1'b0;
      tests_run++;
      if (lvl_valid !== 1'b1 || lvl !== 16'd5 || bit_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_level: vld=%b lvl=%0d rdy=%b want 1 5 0", lvl_valid, $signed(lvl), bit_ready);
      end
      @(negedge clk);
    end
    lvl_ready = 1'b1; bit_valid = 1'b0;
    @(negedge clk);
    lvl_ready = 1'b0;
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++; $display("FAIL hold_done: done=%b want 1", done);
    end
  endtask

  task automatic test_error();
    bit ds, es;
    int used;
    bit_q.delete();
    push_bits("0000000000000000000"); push_bits("1111");
    drive_block(5'd1, 2'd0, 0, 0, 200, ds, es, used);
    tests_run++;
    if (!es || ds || used != 19) begin
      tests_failed++; $display("FAIL err_pulse: err=%b done=%b bits=%0d, want 1 0 19", es, ds, used);
    end
    tests_run++;
    if (busy !== 1'b0 || bit_ready !== 1'b0) begin
      tests_failed++; $display("FAIL err_idle: busy=%b rdy=%b want 0 0", busy, bit_ready);
    end
    @(negedge clk);
    tests_run++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL err_after: err=%b done=%b busy=%b want 0 0 0", err, done, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ds, es;
    int used;
    @(negedge clk);
    start = 1'b1; total_coeff = 5'd4; trail_ones = 2'd3; bit_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bit_valid = 1'b1;
      bit_in = (i == 14) || (i == 16);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || bit_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_suffix: busy=%b rdy=%b want 1 1", busy, bit_ready);
    end
    #2 rst_n = 1'b1;
    #1;
    tests_run++;
    if ({bit_ready, lvl, lvl_valid, busy, done, err, dbg_sl} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: rdy=%b lvl=%h vld=%b busy=%b done=%b err=%b sl=%0d want all 0",
               bit_ready, lvl, lvl_valid, busy, done, err, dbg_sl);
    end
    @(negedge clk);
    rst_n = 1'b0;
    bit_q.delete();
    push_bits("00000000000000"); push_bits("1"); push_bits("0101");
    drive_block(5'd4, 2'd3, 0, 0, 200, ds, es, used);
    tests_run++;
    if (!ds || got_q.size() != 1 || got_q[0] !== 16'hFFF6) begin
      tests_failed++;
      $display("FAIL after_reset: done=%b n=%0d lvl=%0d want 1 1 -10",
               ds, got_q.size(), (got_q.size() > 0) ? $signed(got_q[0]) : 0);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; total_coeff = 5'd3; trail_ones = 2'd3;
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL zero_levels: done=%b busy=%b want 1 0", done, busy);
    end
    total_coeff = 5'd1; trail_ones = 2'd0;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || bit_ready !== 1'b0) begin
      tests_failed++; $display("FAIL start_in_done: busy=%b done=%b rdy=%b want 0 0 0", busy, done, bit_ready);
    end
  endtask

  task automatic test_random();
    bit ds, es;
    int used, sl_end, tc, to;
    for (int n = 0; n < 40; n++) begin
      tc = $urandom_range(0, 16);
      to = $urandom_range(0, (tc < 3) ? tc : 3);
      build_block(tc, to, 3000, sl_end);
      drive_block(5'(tc), 2'(to), $urandom_range(0, 50), $urandom_range(0, 50), 4000, ds, es, used);
      tests_run++;
      if (!ds || es || got_q.size() != exp_q.size() || bit_q.size() != 0) begin
        tests_failed++;
        $display("FAIL rand_block[%0d]: done=%b err=%b n=%0d left=%0d, want 1 0 %0d 0 (tc=%0d to=%0d)",
                 n, ds, es, got_q.size(), bit_q.size(), exp_q.size(), tc, to);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          tests_run++;
          if (got_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL rand_level[%0d][%0d]: got %0d want %0d", n, i, $signed(got_q[i]), $signed(exp_q[i]));
          end
        end
        tests_run++;
        if (dbg_sl !== 3'(sl_end)) begin
          tests_failed++; $display("FAIL rand_sl[%0d]: sl=%0d want %0d", n, dbg_sl, sl_end);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; total_coeff = '0; trail_ones = '0;
    bit_in = 1'b0; bit_valid = 1'b0; lvl_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_escapes();
    test_boundary_prefix18();
    test_sl_adapt();
    test_backpressure();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
